seq_add_bcd: RTL and testbench

//  Button-driven sequential adder: two WIDTH-bit operands are entered from switches on successive

---
 rtl/seq_add_pkg.sv | 53 +++++
 rtl/seq_add_bcd_if.sv | 36 +++
 rtl/seg7_bcd.sv | 27 ++
 rtl/seq_add_bcd.sv | 229 ++++++++++++++++++++++
 tb/tb_seq_add_bcd.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_pkg
// Description : Shared definitions for the sequential BCD adder: FSM state
//               encodings, seven-segment code table and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_add_pkg;

    // One seg_led slice per digit: {enable, dp, g..a}
    localparam int SEG_W = 9;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_WAIT_A = 3'd0;
    localparam state_t ST_CONV_A = 3'd1;
    localparam state_t ST_WAIT_B = 3'd2;
    localparam state_t ST_CONV_R = 3'd3;
    localparam state_t ST_SHOW   = 3'd4;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high g..a pattern for a BCD digit; non-decimal codes are blank
    function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // 10**n, used for the elaboration-time display range check
    function automatic longint pow10(input int n);
        longint acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_add_bcd_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_bcd_if
// Description : Operand/button inputs and result/display outputs of the
//               sequential BCD adder. The sub signal exists only when
//               SEQ_ADD_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_add_bcd_if
    import seq_add_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) ();

    logic [WIDTH-1:0]        num;
    logic                    button;
`ifdef SEQ_ADD_SUB_EN
    logic                    sub;
`endif
    logic [WIDTH:0]          result;
    logic                    neg;
    logic                    busy;
    logic                    valid;
    logic [DIGITS*SEG_W-1:0] seg_led;

`ifdef SEQ_ADD_SUB_EN
    modport master (output num, button, sub, input result, neg, busy, valid, seg_led);
    modport slave  (input num, button, sub, output result, neg, busy, valid, seg_led);
`else
    modport master (output num, button, input result, neg, busy, valid, seg_led);
    modport slave  (input num, button, output result, neg, busy, valid, seg_led);
`endif

endinterface
`default_nettype wire

// File: rtl/seg7_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd
// Description : One display digit: BCD value, blank and decimal point to a
//               {enable, dp, g..a} active-high slice. A blanked digit drives
//               all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd
    import seq_add_pkg::*;
(
    input  wire  [3:0]       i_bcd,
    input  wire              i_blank,
    input  wire              i_dp,
    output logic [SEG_W-1:0] o_seg_led
);

    // Decode the digit, or drive nothing when blanked
    always_comb begin
        o_seg_led = '0;
        if (!i_blank) begin
            o_seg_led = {1'b1, i_dp, seg7_code(i_bcd)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_add_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_bcd
// Description : Button-driven sequential adder. Two operands are captured on
//               successive debounced presses, summed, converted to BCD by an
//               iterative double-dabble engine and shown on DIGITS displays
//               with leading-zero blanking.
//               Optional macro SEQ_ADD_SUB_EN adds a sub input selecting
//               |A-B| with a negative flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_add_bcd
    import seq_add_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DIGITS       = 2,
    parameter int DEBOUNCE_CYC = 240000
) (
    input wire           clk,
    input wire           rst,
    seq_add_bcd_if.slave io
);

    localparam int c_RES_W = WIDTH + 1;
    localparam int c_BCD_W = DIGITS * 4;
    localparam int c_DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_CNT_W = $clog2(c_RES_W + 2);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_RES_W);

    // The display must be able to show the largest possible result
    if (pow10(DIGITS) <= ((64'd1 << c_RES_W) - 64'd1)) begin : g_range_check
        $error("seq_add_bcd: DIGITS too small for WIDTH");
    end

    // Debouncer
    logic [1:0]         r_sync;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_db_level;
    logic               r_db_prev;
    logic               w_press;

    // FSM and datapath
    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_RES_W-1:0] r_result;
    logic               r_neg;
    logic               r_busy;
    logic               r_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_RES_W-1:0] r_bin;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] r_disp_bcd;
    logic               r_disp_neg;
`ifdef SEQ_ADD_SUB_EN
    logic               r_sub;
`endif

    logic [c_RES_W-1:0] w_op;
    logic               w_op_neg;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [c_BCD_W-1:0] w_bcd_shift;
    logic [DIGITS*SEG_W-1:0] w_seg_led;

    // Synchronise the raw button; accept a new level after DEBOUNCE_CYC differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_db_cnt   <= '0;
            r_db_level <= 1'b1;
            r_db_prev  <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], io.button};
            r_db_prev <= r_db_level;
            if (r_sync[1] == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_level <= r_sync[1];
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // Button is active low: a press is the debounced 1->0 edge
    assign w_press = r_db_prev & ~r_db_level;

    // Operation result: sum by default, magnitude of difference when sub was sampled with B
    always_comb begin
        w_op     = {1'b0, r_a} + {1'b0, r_b};
        w_op_neg = 1'b0;
`ifdef SEQ_ADD_SUB_EN
        if (r_sub) begin
            if (r_a < r_b) begin
                w_op     = {1'b0, r_b} - {1'b0, r_a};
                w_op_neg = 1'b1;
            end else begin
                w_op = {1'b0, r_a} - {1'b0, r_b};
            end
        end
`endif
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) begin
                w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = c_BCD_W'({w_bcd_adj, r_bin[c_RES_W-1]});

    // Operand capture, conversion sequencing and display register update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT_A;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_neg      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
`ifdef SEQ_ADD_SUB_EN
            r_sub      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_WAIT_A, ST_SHOW: begin
                    if (w_press) begin
                        r_a     <= io.num;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_CONV_A;
                    end
                end
                ST_WAIT_B: begin
                    if (w_press) begin
                        r_b     <= io.num;
`ifdef SEQ_ADD_SUB_EN
                        r_sub   <= io.sub;
`endif
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_CONV_R;
                    end
                end
                ST_CONV_A, ST_CONV_R: begin
                    // First cycle loads the engine (and the result), the rest shift
                    if (r_cnt == '0) begin
                        r_bcd <= '0;
                        if (r_state == ST_CONV_A) begin
                            r_bin <= {1'b0, r_a};
                        end else begin
                            r_bin    <= w_op;
                            r_result <= w_op;
                            r_neg    <= w_op_neg;
                        end
                    end else begin
                        r_bcd <= w_bcd_shift;
                        r_bin <= r_bin << 1;
                    end
                    // The last shift lands straight in the display register
                    if (r_cnt == c_CNT_LAST) begin
                        r_disp_bcd <= w_bcd_shift;
                        r_busy     <= 1'b0;
                        if (r_state == ST_CONV_A) begin
                            r_disp_neg <= 1'b0;
                            r_state    <= ST_WAIT_B;
                        end else begin
                            r_disp_neg <= r_neg;
                            r_valid    <= 1'b1;
                            r_state    <= ST_SHOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_A;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-digit decode with leading-zero blanking; dp marks the highest lit digit
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        logic w_lit;
        logic w_top;
        if (d == DIGITS - 1) begin : g_msd
            assign w_lit = (d == 0) || (|r_disp_bcd[d*4 +: 4]);
            assign w_top = w_lit;
        end else begin : g_lower
            logic w_above;
            assign w_above = |r_disp_bcd[c_BCD_W-1:(d+1)*4];
            assign w_lit   = (d == 0) || w_above || (|r_disp_bcd[d*4 +: 4]);
            assign w_top   = w_lit & ~w_above;
        end
        seg7_bcd u_seg7 (
            .i_bcd     (r_disp_bcd[d*4 +: 4]),
            .i_blank   (~w_lit),
            .i_dp      (w_top & r_disp_neg),
            .o_seg_led (w_seg_led[d*SEG_W +: SEG_W])
        );
    end

    assign io.result  = r_result;
`ifdef SEQ_ADD_SUB_EN
    assign io.neg     = r_neg;
`else
    assign io.neg     = 1'b0;
`endif
    assign io.busy    = r_busy;
    assign io.valid   = r_valid;
    assign io.seg_led = w_seg_led;

endmodule
`default_nettype wire

// File: tb/tb_seq_add_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_add_bcd
// Description : Directed self-checking bench for seq_add_bcd. A 4-bit/2-digit
//               instance covers reset, addition, bounce rejection, latency,
//               subtraction (SEQ_ADD_SUB_EN) and reset mid-conversion; an
//               8-bit/3-digit instance with a short debounce covers a press
//               landing during result conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_add_bcd;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   press_cnt1;

    seq_add_bcd_if #(.WIDTH(4), .DIGITS(2)) bus1 ();
    seq_add_bcd_if #(.WIDTH(8), .DIGITS(3)) bus2 ();

    seq_add_bcd #(.WIDTH(4), .DIGITS(2), .DEBOUNCE_CYC(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .io  (bus1)
    );

    seq_add_bcd #(.WIDTH(8), .DIGITS(3), .DEBOUNCE_CYC(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .io  (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count press pulses of the small instance
    always @(negedge clk) begin
        if (u_dut1.w_press) press_cnt1 <= press_cnt1 + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a press on instance 1 (optionally preceded by 3-cycle bounces); returns at the pulse
    task automatic press1(input logic [3:0] val, input bit bounce, output bit seen);
        bus1.num = val;
        if (bounce) begin
            for (int g = 0; g < 3; g++) begin
                bus1.button = 1'b0;
                repeat (3) @(negedge clk);
                bus1.button = 1'b1;
                repeat (3) @(negedge clk);
            end
        end
        bus1.button = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (u_dut1.w_press) seen = 1'b1;
        end
    endtask

    task automatic press2(input logic [7:0] val, output bit seen);
        bus2.num    = val;
        bus2.button = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (u_dut2.w_press) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        bit got;
        int cnt0;
        n_checks    = 0;
        n_errors    = 0;
        press_cnt1  = 0;
        rst         = 1'b1;
        bus1.num    = '0;
        bus1.button = 1'b1;
        bus2.num    = '0;
        bus2.button = 1'b1;
`ifdef SEQ_ADD_SUB_EN
        bus1.sub    = 1'b0;
        bus2.sub    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_seg", bus1.seg_led, {9'h000, 9'h13F});
        check_val("rst_valid", bus1.valid, 1'b0);
        check_val("rst_busy", bus1.busy, 1'b0);
        check_val("rst_result", bus1.result, 5'd0);
        check_val("rst_neg", bus1.neg, 1'b0);
        check_val("rst_seg2", bus2.seg_led, {9'h000, 9'h000, 9'h13F});

        // Press landing in CONV_R on the wide instance is dropped
        press2(8'd200, seen);
        check_val("d2_a_seen", seen, 1'b1);
        bus2.button = 1'b1;
        repeat (15) @(negedge clk);
        press2(8'd100, seen);
        check_val("d2_b_seen", seen, 1'b1);
        bus2.button = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (u_dut2.r_db_level) got = 1'b1;
        end
        check_val("d2_release", got, 1'b1);
        press2(8'd55, seen);
        check_val("d2_drop_seen", seen, 1'b1);
        check_val("d2_drop_busy", bus2.busy, 1'b1);
        bus2.button = 1'b1;
        repeat (20) @(negedge clk);
        check_val("d2_result", bus2.result, 9'd300);
        check_val("d2_a", u_dut2.r_a, 8'd200);
        check_val("d2_b", u_dut2.r_b, 8'd100);
        check_val("d2_valid", bus2.valid, 1'b1);
        check_val("d2_seg", bus2.seg_led, {9'h14F, 9'h13F, 9'h13F});

        // Bounced A press yields a single pulse
        cnt0 = press_cnt1;
        press1(4'd9, 1'b1, seen);
        check_val("a9_seen", seen, 1'b1);
        bus1.button = 1'b1;
        @(negedge clk);
        check_val("a9_busy", bus1.busy, 1'b1);
        repeat (12) @(negedge clk);
        check_val("bounce_one_pulse", press_cnt1, cnt0 + 1);
        check_val("a9_disp", bus1.seg_led, {9'h000, 9'h16F});
        check_val("a9_valid", bus1.valid, 1'b0);

        // B press and valid latency of WIDTH+3 cycles
        press1(4'd8, 1'b0, seen);
        check_val("b8_seen", seen, 1'b1);
        bus1.button = 1'b1;
        repeat (6) @(negedge clk);
        check_val("valid_early", bus1.valid, 1'b0);
        @(negedge clk);
        check_val("valid_latency", bus1.valid, 1'b1);
        check_val("sum17_result", bus1.result, 5'd17);
        check_val("sum17_neg", bus1.neg, 1'b0);
        check_val("sum17_seg", bus1.seg_led, {9'h106, 9'h107});
        check_val("sum17_busy", bus1.busy, 1'b0);

        // New A from SHOW, then 15 + 15
        repeat (4) @(negedge clk);
        press1(4'd15, 1'b0, seen);
        bus1.button = 1'b1;
        @(negedge clk);
        check_val("show_new_a_valid", bus1.valid, 1'b0);
        repeat (12) @(negedge clk);
        press1(4'd15, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (12) @(negedge clk);
        check_val("sum30_result", bus1.result, 5'd30);
        check_val("sum30_seg", bus1.seg_led, {9'h14F, 9'h13F});
        check_val("sum30_valid", bus1.valid, 1'b1);

`ifdef SEQ_ADD_SUB_EN
        // 3 - 7 = -4
        press1(4'd3, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (12) @(negedge clk);
        bus1.sub = 1'b1;
        press1(4'd7, 1'b0, seen);
        bus1.button = 1'b1;
        bus1.sub = 1'b0;
        repeat (12) @(negedge clk);
        check_val("sub_result", bus1.result, 5'd4);
        check_val("sub_neg", bus1.neg, 1'b1);
        check_val("sub_seg", bus1.seg_led, {9'h000, 9'h1E6});
`endif

        // Reset in the middle of CONV_R
        press1(4'd5, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (12) @(negedge clk);
        press1(4'd6, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (3) @(negedge clk);
        check_val("convr_busy", bus1.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_busy", bus1.busy, 1'b0);
        check_val("midrst_valid", bus1.valid, 1'b0);
        check_val("midrst_seg", bus1.seg_led, {9'h000, 9'h13F});
        check_val("midrst_result", bus1.result, 5'd0);
        rst = 1'b0;
        @(negedge clk);

        // FSM restarted in WAIT_A: first press is A, second is B
        press1(4'd2, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (12) @(negedge clk);
        check_val("post_rst_a_disp", bus1.seg_led, {9'h000, 9'h15B});
        press1(4'd3, 1'b0, seen);
        bus1.button = 1'b1;
        repeat (12) @(negedge clk);
        check_val("post_rst_sum", bus1.result, 5'd5);
        check_val("post_rst_valid", bus1.valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
